player_motion_ctrl: RTL and testbench

//  Per-player movement/action controller, successor to the single-player mover. Updates once per frame:

---
 rtl/overcooked_pkg.sv | 32 +++
 rtl/player_motion_ctrl_if.sv | 31 +++
 rtl/player_chop_timer.sv | 33 +++
 rtl/player_motion_ctrl.sv | 172 +++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/overcooked_pkg.sv
// Shared types for the per-player controllers: facing direction and player state encodings.
package overcooked_pkg;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WALK       = 4'd1,
        ST_CHOP       = 4'd2,
        ST_CARRY_IDLE = 4'd3,
        ST_CARRY_WALK = 4'd4
    } pstate_t;

    // Single-axis pick: up > down > left > right.
    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        if (up)
            return DIR_U;
        else if (down)
            return DIR_D;
        else if (left)
            return DIR_L;
        else
            return DIR_R;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Button inputs and sprite/game-logic outputs of one player controller.
interface player_motion_ctrl_if #(parameter int COORD_W = 9);

    logic               left;
    logic               right;
    logic               up;
    logic               down;
    logic               chop;
    logic               carry;
    logic [3:0]         blocked;
    logic [1:0]         player_direction;
    logic [COORD_W-1:0] player_loc_x;
    logic [COORD_W-1:0] player_loc_y;
    logic [3:0]         player_state;
    logic               holding;
    logic [1:0]         anim_frame;
    logic               chop_done;

    modport master (
        output left, right, up, down, chop, carry, blocked,
        input  player_direction, player_loc_x, player_loc_y, player_state,
               holding, anim_frame, chop_done
    );

    modport slave (
        input  left, right, up, down, chop, carry, blocked,
        output player_direction, player_loc_x, player_loc_y, player_state,
               holding, anim_frame, chop_done
    );

endinterface

// File: rtl/player_chop_timer.sv
// Chop hold timer: counts frames while chop is held and pulses chop_done on the completing frame.
module player_chop_timer #(
    parameter int CHOP_FRAMES = 60
) (
    input  logic vsync,
    input  logic reset_n,
    input  logic run,
    output logic expire,
    output logic chop_done
);

    localparam int CW = (CHOP_FRAMES > 2) ? $clog2(CHOP_FRAMES) : 1;
    // Count sits one below the target when the completing increment is about to happen.
    localparam logic [CW-1:0] PRE_LAST = CW'(CHOP_FRAMES - 2);

    logic [CW-1:0] cnt_q;

    assign expire = run && (cnt_q == PRE_LAST);

    always_ff @(negedge vsync or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            chop_done <= 1'b0;
        end else begin
            chop_done <= expire;
            if (run && !expire)
                cnt_q <= cnt_q + CW'(1);
            else
                cnt_q <= '0;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player movement/action controller, updated on the falling edge of vsync.
// Define DIAG_MOVE_EN to resolve x and y independently (diagonal moves).
//
//  state          | meaning
//  ST_IDLE        | standing, empty-handed
//  ST_WALK        | moving, empty-handed
//  ST_CHOP        | chop held; movement and carry ignored
//  ST_CARRY_IDLE  | standing while holding an item
//  ST_CARRY_WALK  | moving while holding an item
module player_motion_ctrl
    import overcooked_pkg::*;
#(
    parameter int COORD_W     = 9,
    parameter int X_MIN       = 144,
    parameter int X_MAX       = 464,
    parameter int Y_MIN       = 144,
    parameter int Y_MAX       = 304,
    parameter int START_X     = 304,
    parameter int START_Y     = 208,
    parameter int STEP        = 4,
    parameter int CHOP_FRAMES = 60,
    parameter int ANIM_DIV    = 8
) (
    input  logic                 vsync,
    input  logic                 reset_n,
    player_motion_ctrl_if.slave  bus
);

    typedef logic [COORD_W:0] wide_t;

    localparam wide_t XLO = wide_t'(X_MIN);
    localparam wide_t XHI = wide_t'(X_MAX);
    localparam wide_t YLO = wide_t'(Y_MIN);
    localparam wide_t YHI = wide_t'(Y_MAX);
    localparam wide_t STP = wide_t'(STEP);
    localparam logic [COORD_W-1:0] X0 = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y0 = COORD_W'(START_Y);
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [AW-1:0] DIV_LAST = AW'(ANIM_DIV - 1);

    // One extra bit of headroom so the clamp compare can never wrap.
    function automatic logic [COORD_W-1:0] step_pos(input logic [COORD_W-1:0] pos,
                                                     input logic inc,
                                                     input wide_t lo, input wide_t hi);
        wide_t p;
        p = {1'b0, pos};
        if (inc)
            return (p + STP > hi) ? COORD_W'(hi) : COORD_W'(p + STP);
        else
            return (p < lo + STP) ? COORD_W'(lo) : COORD_W'(p - STP);
    endfunction

    dir_t               dir_q, dir_n;
    pstate_t            state_q, state_n;
    logic [COORD_W-1:0] x_q, x_n, y_q, y_n;
    logic               holding_q, holding_n;
    logic [1:0]         anim_q, anim_n;
    logic [AW-1:0]      div_q, div_n;
    logic               carry_q;
    logic               any_dir;
    logic               chop_run;
    logic               chop_expire;
`ifdef DIAG_MOVE_EN
    dir_t               h_dir;
`endif

    assign chop_run = (state_q == ST_CHOP) && bus.chop;

    player_chop_timer #(.CHOP_FRAMES(CHOP_FRAMES)) u_chop_timer (
        .vsync     (vsync),
        .reset_n   (reset_n),
        .run       (chop_run),
        .expire    (chop_expire),
        .chop_done (bus.chop_done)
    );

    always_comb begin
        dir_n     = dir_q;
        x_n       = x_q;
        y_n       = y_q;
        state_n   = state_q;
        holding_n = holding_q;
        anim_n    = anim_q;
        div_n     = div_q;
        any_dir   = bus.up | bus.down | bus.left | bus.right;
`ifdef DIAG_MOVE_EN
        h_dir     = bus.left ? DIR_L : DIR_R;
`endif

        if (state_q == ST_CHOP) begin
            if (!bus.chop || chop_expire)
                state_n = ST_IDLE;
        end else begin
            if (bus.carry && !carry_q)
                holding_n = ~holding_q;

            if (any_dir) begin
`ifdef DIAG_MOVE_EN
                if (bus.up || bus.down) begin
                    dir_n = bus.up ? DIR_U : DIR_D;
                    if (!bus.blocked[dir_n])
                        y_n = step_pos(y_q, !bus.up, YLO, YHI);
                end
                if (bus.left || bus.right) begin
                    if (!(bus.up || bus.down))
                        dir_n = h_dir;
                    if (!bus.blocked[h_dir])
                        x_n = step_pos(x_q, !bus.left, XLO, XHI);
                end
`else
                dir_n = pick_dir(bus.up, bus.down, bus.left, bus.right);
                if (!bus.blocked[dir_n]) begin
                    case (dir_n)
                        DIR_U:   y_n = step_pos(y_q, 1'b0, YLO, YHI);
                        DIR_D:   y_n = step_pos(y_q, 1'b1, YLO, YHI);
                        DIR_L:   x_n = step_pos(x_q, 1'b0, XLO, XHI);
                        default: x_n = step_pos(x_q, 1'b1, XLO, XHI);
                    endcase
                end
`endif
                state_n = holding_n ? ST_CARRY_WALK : ST_WALK;
            end else if (state_q == ST_IDLE && bus.chop && !holding_n) begin
                state_n = ST_CHOP;
            end else begin
                state_n = holding_n ? ST_CARRY_IDLE : ST_IDLE;
            end
        end

        // Animation follows the state being entered so it restarts cleanly on every walk.
        if (state_n == ST_WALK || state_n == ST_CARRY_WALK) begin
            if (div_q == DIV_LAST) begin
                div_n  = '0;
                anim_n = anim_q + 2'd1;
            end else begin
                div_n = div_q + AW'(1);
            end
        end else begin
            div_n  = '0;
            anim_n = '0;
        end
    end

    always_ff @(negedge vsync or negedge reset_n) begin
        if (!reset_n) begin
            dir_q     <= DIR_D;
            x_q       <= X0;
            y_q       <= Y0;
            state_q   <= ST_IDLE;
            holding_q <= 1'b0;
            anim_q    <= '0;
            div_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            dir_q     <= dir_n;
            x_q       <= x_n;
            y_q       <= y_n;
            state_q   <= state_n;
            holding_q <= holding_n;
            anim_q    <= anim_n;
            div_q     <= div_n;
            carry_q   <= bus.carry;
        end
    end

    assign bus.player_direction = dir_q;
    assign bus.player_loc_x     = x_q;
    assign bus.player_loc_y     = y_q;
    assign bus.player_state     = state_q;
    assign bus.holding          = holding_q;
    assign bus.anim_frame       = anim_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl; a second instance starts next to the bounds for clamp checks.
module tb_player_motion_ctrl;

    logic vsync;
    logic reset_n;
    int   vectors = 0;
    int   fails   = 0;
    int   pulses  = 0;
    int   pulse_base;

    player_motion_ctrl_if #(.COORD_W(9)) bus ();
    player_motion_ctrl_if #(.COORD_W(9)) bus2 ();

    player_motion_ctrl u_dut (
        .vsync   (vsync),
        .reset_n (reset_n),
        .bus     (bus)
    );

    player_motion_ctrl #(.START_X(146), .START_Y(302)) u_edge (
        .vsync   (vsync),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial begin
        vsync = 1'b1;
        forever #5 vsync = ~vsync;
    end

    always @(posedge vsync) if (bus.chop_done === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int n);
        repeat (n) @(negedge vsync);
        #1;
    endtask

    task automatic idle_inputs();
        bus.left = 0; bus.right = 0; bus.up = 0; bus.down = 0;
        bus.chop = 0; bus.carry = 0; bus.blocked = 4'b0000;
        bus2.left = 0; bus2.right = 0; bus2.up = 0; bus2.down = 0;
        bus2.chop = 0; bus2.carry = 0; bus2.blocked = 4'b0000;
    endtask

    initial begin
        int exp_v;
        idle_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_x", bus.player_loc_x, 304);
        check("rst_y", bus.player_loc_y, 208);
        check("rst_dir", bus.player_direction, 3);
        check("rst_state", bus.player_state, 0);
        check("rst_hold", bus.holding, 0);
        check("rst_anim", bus.anim_frame, 0);
        check("rst_done", bus.chop_done, 0);
        #5 reset_n = 1'b1;

        // Walk up into Y_MIN
        bus.up = 1;
        for (int k = 1; k <= 20; k++) begin
            frame(1);
            exp_v = (208 - 4 * k < 144) ? 144 : 208 - 4 * k;
            check("up_y", bus.player_loc_y, exp_v);
        end
        check("up_dir", bus.player_direction, 2);
        check("up_state", bus.player_state, 1);
        check("up_anim", bus.anim_frame, 2);
        check("up_x", bus.player_loc_x, 304);
        bus.up = 0;
        frame(1);
        check("stop_state", bus.player_state, 0);
        check("stop_anim", bus.anim_frame, 0);
        check("stop_dir", bus.player_direction, 2);

        // left+right: left wins, walk into X_MIN
        bus.left = 1; bus.right = 1;
        for (int k = 1; k <= 42; k++) begin
            frame(1);
            exp_v = (304 - 4 * k < 144) ? 144 : 304 - 4 * k;
            check("lr_x", bus.player_loc_x, exp_v);
        end
        check("lr_dir", bus.player_direction, 0);
        bus.left = 0; bus.right = 0;
        frame(1);

        // Blocked right: no motion, facing and animation still update
        bus.blocked = 4'b0010; bus.right = 1;
        frame(7);
        check("blk_anim7", bus.anim_frame, 0);
        frame(1);
        check("blk_anim8", bus.anim_frame, 1);
        frame(8);
        check("blk_anim16", bus.anim_frame, 2);
        check("blk_x", bus.player_loc_x, 144);
        check("blk_dir", bus.player_direction, 1);
        check("blk_state", bus.player_state, 1);
        bus.blocked = 4'b0000; bus.right = 0;
        frame(1);

        // Full chop
        pulse_base = pulses;
        bus.chop = 1;
        frame(1);
        check("chop_enter", bus.player_state, 2);
        frame(58);
        check("chop59_state", bus.player_state, 2);
        check("chop59_done", bus.chop_done, 0);
        frame(1);
        check("chop60_done", bus.chop_done, 1);
        check("chop60_state", bus.player_state, 0);
        bus.chop = 0;
        frame(1);
        check("chop61_done", bus.chop_done, 0);
        check("chop_pulses", pulses - pulse_base, 1);

        // Chop released at 30 with down pressed meanwhile
        pulse_base = pulses;
        bus.chop = 1;
        frame(4);
        bus.down = 1;
        frame(26);
        check("chop30_state", bus.player_state, 2);
        check("chop30_y", bus.player_loc_y, 144);
        check("chop30_dir", bus.player_direction, 1);
        bus.chop = 0; bus.down = 0;
        frame(1);
        check("rel_state", bus.player_state, 0);
        frame(40);
        check("rel_pulses", pulses - pulse_base, 0);

        // Carry toggling
        bus.carry = 1;
        frame(1);
        check("carry_hold", bus.holding, 1);
        check("carry_state", bus.player_state, 3);
        frame(1);
        check("carry_level_hold", bus.holding, 1);
        bus.carry = 0;
        frame(1);
        bus.right = 1;
        frame(1);
        check("cwalk_state", bus.player_state, 4);
        check("cwalk_x", bus.player_loc_x, 148);
        bus.right = 0;
        frame(1);
        check("cidle_state", bus.player_state, 3);
        bus.chop = 1;
        frame(1);
        check("chop_holding", bus.player_state, 3);
        bus.chop = 0;
        bus.carry = 1;
        frame(1);
        check("drop_hold", bus.holding, 0);
        check("drop_state", bus.player_state, 0);
        bus.carry = 0;
        bus.chop = 1;
        frame(1);
        bus.carry = 1;
        frame(1);
        check("chopcarry_hold", bus.holding, 0);
        check("chopcarry_state", bus.player_state, 2);
        bus.carry = 0; bus.chop = 0;
        frame(1);
        check("chopcarry_idle", bus.player_state, 0);
        bus.right = 1; bus.carry = 1;
        frame(1);
        check("walkpick_hold", bus.holding, 1);
        check("walkpick_state", bus.player_state, 4);
        check("walkpick_x", bus.player_loc_x, 152);
        bus.right = 0; bus.carry = 0;
        frame(1);
        check("walkpick_idle", bus.player_state, 3);
        bus.carry = 1;
        frame(1);
        check("drop2_state", bus.player_state, 0);
        bus.carry = 0;

        // Down then up+right
        bus.down = 1;
        frame(4);
        check("down_y", bus.player_loc_y, 160);
        check("down_dir", bus.player_direction, 3);
        bus.down = 0; bus.up = 1; bus.right = 1;
        frame(1);
        check("ur_y", bus.player_loc_y, 156);
        check("ur_dir", bus.player_direction, 2);
`ifdef DIAG_MOVE_EN
        check("ur_x", bus.player_loc_x, 156);
`else
        check("ur_x", bus.player_loc_x, 152);
`endif
        bus.up = 0; bus.right = 0;
        frame(1);

        // Clamp instance: x=146, y=302
        bus2.left = 1;
        frame(1);
        check("xmin_x1", bus2.player_loc_x, 144);
        frame(1);
        check("xmin_x2", bus2.player_loc_x, 144);
        check("xmin_dir", bus2.player_direction, 0);
        bus2.left = 0; bus2.down = 1;
        frame(1);
        check("ymax_y1", bus2.player_loc_y, 304);
        frame(1);
        check("ymax_y2", bus2.player_loc_y, 304);
        check("ymax_dir", bus2.player_direction, 3);
        bus2.down = 0;

        // Mid-frame asynchronous reset
        @(posedge vsync);
        #2 reset_n = 1'b0;
        #1;
        check("arst_x", bus.player_loc_x, 304);
        check("arst_y", bus.player_loc_y, 208);
        check("arst_dir", bus.player_direction, 3);
        check("arst_state", bus.player_state, 0);
        check("arst_hold", bus.holding, 0);
        #3 reset_n = 1'b1;
        frame(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
